// File: rtl/mips32_pkg.sv
// Shared MIPS32 core definitions: opcodes, instruction classes and the
// fetch front-end state encoding.
package mips32_pkg;

    localparam int WORD_W = 32;

    localparam logic [5:0] ADD   = 6'b000000;
    localparam logic [5:0] SUB   = 6'b000001;
    localparam logic [5:0] AND   = 6'b000010;
    localparam logic [5:0] OR    = 6'b000011;
    localparam logic [5:0] SLT   = 6'b000100;
    localparam logic [5:0] MUL   = 6'b000101;
    localparam logic [5:0] LW    = 6'b001000;
    localparam logic [5:0] SW    = 6'b001001;
    localparam logic [5:0] ADDI  = 6'b001010;
    localparam logic [5:0] SUBI  = 6'b001011;
    localparam logic [5:0] SLTI  = 6'b001100;
    localparam logic [5:0] BNEQZ = 6'b001101;
    localparam logic [5:0] BEQZ  = 6'b001110;
    localparam logic [5:0] HLT   = 6'b111111;

    localparam logic [2:0] RR_ALU = 3'd0;
    localparam logic [2:0] RM_ALU = 3'd1;
    localparam logic [2:0] LOAD   = 3'd2;
    localparam logic [2:0] STORE  = 3'd3;
    localparam logic [2:0] BRANCH = 3'd4;
    localparam logic [2:0] HALT   = 3'd5;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/mips32_sync_fifo.sv
// Single-clock FIFO with synchronous clear; a pop in the same cycle frees
// the slot for a push even when full.
module mips32_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk1,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/mips32_fetch_queue.sv
// Instruction fetch front end: credit-limited imem requests, in-order
// response capture into a decode queue, redirect flush and halt parking.
module mips32_fetch_queue
    import mips32_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = 10,
    parameter int RESET_PC = 0
) (
    input  logic              clk1,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_ir,
    output logic [ADDR_W-1:0] out_npc,
    output logic              halted
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int QW = WORD_W + ADDR_W;
    localparam logic [CW:0]       DEPTH_C    = (CW+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] RESET_PC_C = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);

    localparam logic [1:0] ST_RUN    = RUN;
    localparam logic [1:0] ST_FLUSH  = FLUSH;
    localparam logic [1:0] ST_HALTED = HALTED;

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc, rsp_pc;
    logic [CW-1:0]     outstanding, outstanding_nxt, q_count;
    logic [CW:0]       credit_used;
    logic              redir, accept, rsp_dec;
    logic              q_push, q_pop, q_full, q_empty;
    logic [QW-1:0]     q_wdata, q_rdata;

    assign redir       = redirect_valid & (state != ST_HALTED);
    assign credit_used = {1'b0, q_count} + {1'b0, outstanding};

    // Queue slots plus in-flight requests never exceed DEPTH, so every
    // response always has a slot waiting for it.
    assign imem_req_valid = rst_n & (state == ST_RUN) & ~halt & ~redirect_valid
                          & (credit_used < DEPTH_C);
    assign imem_req_addr  = pc;
    assign accept         = imem_req_valid & imem_req_ready;

    assign rsp_dec         = imem_rsp_valid & (outstanding != '0);
    assign outstanding_nxt = outstanding + CW'(accept) - CW'(rsp_dec);

    assign q_push  = imem_rsp_valid & (state == ST_RUN) & ~redirect_valid & (~q_full | q_pop);
    assign q_wdata = {imem_rsp_data, rsp_pc + ONE};

    assign out_valid = ~q_empty & ~redirect_valid & (state != ST_HALTED);
    assign q_pop     = out_valid & out_ready;
    assign out_ir    = q_rdata[QW-1 -: WORD_W];
    assign out_npc   = q_rdata[ADDR_W-1:0];
    assign halted    = (state == ST_HALTED);

    mips32_sync_fifo #(
        .WIDTH (QW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk1  (clk1),
        .rst_n (rst_n),
        .push  (q_push),
        .pop   (q_pop),
        .clear (redir),
        .wdata (q_wdata),
        .rdata (q_rdata),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            pc          <= RESET_PC_C;
            rsp_pc      <= RESET_PC_C;
            outstanding <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (redir) begin
                pc     <= redirect_pc;
                rsp_pc <= redirect_pc;
            end else begin
                if (accept) pc     <= pc + ONE;
                if (q_push) rsp_pc <= rsp_pc + ONE;
            end
            case (state)
                ST_RUN, ST_FLUSH: begin
                    // Park only once nothing remains in flight
                    if (halt && outstanding_nxt == '0)
                        state <= ST_HALTED;
                    else if (redir)
                        state <= (outstanding_nxt != '0) ? ST_FLUSH : ST_RUN;
                    else if (state == ST_FLUSH && outstanding_nxt == '0)
                        state <= ST_RUN;
                end
                ST_HALTED: ;
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Randomized bench for mips32_fetch_queue against a queue-based reference
// model of memory, decode queue and redirect/halt behaviour.
module tb_mips32_fetch_queue;

    localparam int DEPTH    = 4;
    localparam int ADDR_W   = 10;
    localparam int RESET_PC = 0;

    logic              clk1 = 1'b0;
    logic              rst_n = 1'b0;
    logic              imem_req_valid, imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [31:0]       imem_rsp_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt;
    logic              out_valid, out_ready;
    logic [31:0]       out_ir;
    logic [ADDR_W-1:0] out_npc;
    logic              halted;

    mips32_fetch_queue #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk1           (clk1),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_ir         (out_ir),
        .out_npc        (out_npc),
        .halted         (halted)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        logic [ADDR_W-1:0] a;
        int                due;
    } mreq_t;

    mreq_t             memq[$];   // accepted, not yet answered
    logic [ADDR_W-1:0] pend[$];   // addresses waiting in the decode queue
    logic [ADDR_W-1:0] exp_req;
    bit                tb_flush, tb_halted;

    int cyc, lat, rdy_pct, ordy_pct;
    int n_chk, n_fail;
    int obs_acc, obs_pop, first_ov_cyc;
    bit drv_redir, drv_halt;
    logic [ADDR_W-1:0] drv_rpc;
    bit arm, cap_seen;
    logic [ADDR_W-1:0] cap_npc;

    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
        return {12'hC0D, a, ~a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, then advance model.
    task automatic tick();
        bit rsp, exp_rv, exp_ov, acc, pop;
        logic [ADDR_W-1:0] ra, npc;
        imem_req_ready = ($urandom_range(99) < rdy_pct);
        out_ready      = ($urandom_range(99) < ordy_pct);
        redirect_valid = drv_redir;
        redirect_pc    = drv_rpc;
        halt           = drv_halt;
        rsp = 1'b0;
        if (memq.size() > 0) rsp = (memq[0].due <= cyc);
        imem_rsp_valid = rsp;
        if (rsp) imem_rsp_data = mem_word(memq[0].a);
        else     imem_rsp_data = $urandom;
        @(negedge clk1);
        exp_rv = !tb_halted && !tb_flush && !drv_halt && !drv_redir
               && (pend.size() + memq.size() < DEPTH);
        exp_ov = (pend.size() > 0) && !drv_redir && !tb_halted;
        chk("req_valid", 64'(imem_req_valid), 64'(exp_rv));
        if (exp_rv) chk("req_addr", 64'(imem_req_addr), 64'(exp_req));
        chk("out_valid", 64'(out_valid), 64'(exp_ov));
        if (exp_ov) begin
            npc = pend[0] + 10'd1;
            chk("out_ir", 64'(out_ir), 64'(mem_word(pend[0])));
            chk("out_npc", 64'(out_npc), 64'(npc));
        end
        chk("halted", 64'(halted), 64'(tb_halted));
        if (imem_req_valid && imem_req_ready) obs_acc++;
        if (out_valid && out_ready) begin
            obs_pop++;
            if (arm && !cap_seen) begin
                cap_npc  = out_npc;
                cap_seen = 1'b1;
            end
        end
        if (first_ov_cyc < 0 && out_valid) first_ov_cyc = cyc;
        acc = exp_rv && imem_req_ready;
        pop = exp_ov && out_ready;
        if (pop) void'(pend.pop_front());
        if (rsp) begin
            ra = memq[0].a;
            void'(memq.pop_front());
            if (!drv_redir && !tb_flush && !tb_halted) pend.push_back(ra);
        end
        if (acc) begin
            memq.push_back('{a: exp_req, due: cyc + lat});
            exp_req++;
        end
        if (!tb_halted) begin
            if (drv_halt && memq.size() == 0) begin
                tb_halted = 1'b1;
                tb_flush  = 1'b0;
            end else if (drv_redir) begin
                pend.delete();
                exp_req  = drv_rpc;
                tb_flush = (memq.size() > 0);
            end else if (tb_flush && memq.size() == 0) begin
                tb_flush = 1'b0;
            end
        end
        @(posedge clk1);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_outs(input int n, input string tag);
        int k;
        k = 0;
        while (memq.size() != n && k < 30) begin
            tick();
            k++;
        end
        chk(tag, 64'(memq.size()), 64'(n));
    endtask

    task automatic arm_cap();
        arm      = 1'b1;
        cap_seen = 1'b0;
        cap_npc  = 'x;
    endtask

    task automatic wait_cap(input string tag, input logic [ADDR_W-1:0] exp);
        int k;
        k = 0;
        while (!cap_seen && k < 40) begin
            tick();
            k++;
        end
        chk(tag, 64'(cap_npc), 64'(exp));
        arm = 1'b0;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_req_addr", 64'(imem_req_addr), 64'(RESET_PC));
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_ir", 64'(out_ir), 64'd0);
        chk("rst_out_npc", 64'(out_npc), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        memq.delete();
        pend.delete();
        tb_flush  = 1'b0;
        tb_halted = 1'b0;
        exp_req   = ADDR_W'(RESET_PC);
        drv_redir = 1'b0;
        drv_halt  = 1'b0;
        redirect_valid = 1'b0;
        halt           = 1'b0;
        imem_rsp_valid = 1'b0;
        @(posedge clk1);
        @(posedge clk1);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0;
        obs_acc = 0; obs_pop = 0; first_ov_cyc = -1;
        lat = 1; rdy_pct = 100; ordy_pct = 100;
        drv_redir = 1'b0; drv_halt = 1'b0; drv_rpc = '0;
        arm = 1'b0; cap_seen = 1'b0; cap_npc = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0; out_ready = 1'b0;
        do_reset();

        // Streaming with 1-cycle memory
        run(20);
        chk("first_ov_cyc", 64'(first_ov_cyc), 64'd2);
        chk("steady_pops", 64'(obs_pop), 64'd18);

        // Decode stalls: requests stop once queue plus in-flight reach DEPTH
        begin
            int occ0;
            occ0 = pend.size() + memq.size();
            ordy_pct = 0;
            obs_acc  = 0;
            run(10);
            chk("fill_reqs", 64'(obs_acc), 64'(DEPTH - occ0));
            ordy_pct = 100;
            run(10);
        end

        // Redirect with three requests in flight on 3-cycle memory
        lat = 3;
        wait_outs(3, "wait_out3");
        arm_cap();
        drv_redir = 1'b1; drv_rpc = 10'h100;
        tick();
        drv_redir = 1'b0;
        wait_cap("redir_npc", 10'h101);

        // Redirect coincident with a response and decode ready; target wraps
        lat = 1;
        run(6);
        arm_cap();
        drv_redir = 1'b1; drv_rpc = 10'h3FE;
        tick();
        drv_redir = 1'b0;
        wait_cap("wrap_npc", 10'h3FF);
        run(6);

        // Random traffic
        rdy_pct = 70; ordy_pct = 70;
        for (int i = 0; i < 400; i++) begin
            lat       = $urandom_range(4, 1);
            drv_redir = ($urandom_range(99) < 4);
            drv_rpc   = ADDR_W'($urandom);
            tick();
        end
        drv_redir = 1'b0;
        lat = 1; rdy_pct = 100; ordy_pct = 100;
        run(10);

        // Halt with two requests outstanding, then redirect while parked
        lat = 3;
        wait_outs(2, "wait_out2");
        drv_halt = 1'b1;
        begin
            int k;
            k = 0;
            while (!halted && k < 30) begin
                tick();
                k++;
            end
        end
        chk("halt_reached", 64'(halted), 64'd1);
        obs_acc = 0; obs_pop = 0;
        drv_redir = 1'b1; drv_rpc = 10'h055;
        tick();
        drv_redir = 1'b0;
        run(5);
        chk("halt_no_req", 64'(obs_acc), 64'd0);
        chk("halt_no_out", 64'(obs_pop), 64'd0);

        // Reset clears the parked state, then reset again mid-stream
        do_reset();
        lat = 1;
        run(6);
        do_reset();
        arm_cap();
        wait_cap("restart_npc", ADDR_W'(RESET_PC + 1));
        run(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
